dma_bus_arbiter: RTL and testbench

DMA_BUS_ARBITER -- requirements
Module: dma_bus_arbiter

---
 rtl/dma_bus_arbiter_pkg.sv | 18 +
 rtl/dma_bus_arbiter.sv | 136 +++++++++++++
 tb/tb_dma_bus_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/dma_bus_arbiter_pkg.sv
// Shared SDMAC definitions for the DMA bus arbiter: tenure state encoding and
// default tuning values for bus budget, backoff and grant timeout.
package dma_bus_arbiter_pkg;

  localparam int unsigned DefMaxXfers     = 16;
  localparam int unsigned DefBackoffCycles = 4;
  localparam int unsigned DefGrantTimeout = 255;

  typedef enum logic [2:0] {
    StIdle,
    StRequest,
    StAcquire,
    StOwned,
    StRelease,
    StBackoff
  } arb_state_e;

endpackage

// File: rtl/dma_bus_arbiter.sv
// 68030 bus-request/grant/acknowledge arbiter for the SDMAC: obtains the bus for DMA,
// bounds each tenure by a cycle budget and backs off after a budget-forced release.
module dma_bus_arbiter
  import dma_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_XFERS      = DefMaxXfers,
  parameter int unsigned BACKOFF_CYCLES = DefBackoffCycles,
  parameter int unsigned GRANT_TIMEOUT  = DefGrantTimeout
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       DMAREQ,
  input  logic       BGRANT_,
  input  logic       BGACK_IN_,
  input  logic       AS_,
  input  logic       CYCLEDONE,
  output logic       BR_,
  output logic       BGACK_,
  output logic       OWN,
  output logic [7:0] XFER_CNT,
  output logic       TIMEOUT_ERR
);

  arb_state_e state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [3:0] backoff_q, backoff_d;
  logic [7:0] xfer_q, xfer_d;
  logic       exhausted_q, exhausted_d;
  logic       br_q, br_d;
  logic       bgack_q, bgack_d;
  logic       own_q, own_d;
  logic       timeout_q, timeout_d;
  logic [8:0] xfer_inc;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    backoff_d   = backoff_q;
    xfer_d      = xfer_q;
    exhausted_d = exhausted_q;
    timeout_d   = 1'b0;
    xfer_inc    = {1'b0, xfer_q} + 9'd1;

    unique case (state_q)
      StIdle: begin
        if (DMAREQ) begin
          state_d = StRequest;
          wait_d  = '0;
        end
      end
      StRequest: begin
        wait_d = wait_q + 8'd1;
        if (!BGRANT_) begin
          state_d = StAcquire;
        end else if (!DMAREQ) begin
          state_d = StIdle;
        end else if (32'(wait_d) == GRANT_TIMEOUT) begin
          state_d   = StIdle;
          timeout_d = 1'b1;
        end
      end
      StAcquire: begin
        // A withdrawn grant restarts the request with a fresh timeout window.
        if (BGRANT_) begin
          state_d = StRequest;
          wait_d  = '0;
        end else if (AS_ && BGACK_IN_) begin
          state_d     = StOwned;
          xfer_d      = '0;
          exhausted_d = 1'b0;
        end
      end
      StOwned: begin
        // Release decisions are taken only on a cycle boundary.
        if (CYCLEDONE) begin
          xfer_d      = xfer_inc[8] ? 8'hff : xfer_inc[7:0];
          exhausted_d = (32'(xfer_inc) == MAX_XFERS);
          if (!DMAREQ || exhausted_d) begin
            state_d = StRelease;
          end
        end
      end
      StRelease: begin
        if (exhausted_q) begin
          state_d   = StBackoff;
          backoff_d = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StBackoff: begin
        backoff_d = backoff_q + 4'd1;
        if (32'(backoff_d) == BACKOFF_CYCLES) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered copies of the decode of the next state.
    br_d    = !(state_d inside {StRequest, StAcquire});
    bgack_d = !(state_d inside {StOwned, StRelease});
    own_d   = (state_d == StOwned);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      backoff_q   <= '0;
      xfer_q      <= '0;
      exhausted_q <= 1'b0;
      br_q        <= 1'b1;
      bgack_q     <= 1'b1;
      own_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      backoff_q   <= backoff_d;
      xfer_q      <= xfer_d;
      exhausted_q <= exhausted_d;
      br_q        <= br_d;
      bgack_q     <= bgack_d;
      own_q       <= own_d;
      timeout_q   <= timeout_d;
    end
  end

  assign BR_         = br_q;
  assign BGACK_      = bgack_q;
  assign OWN         = own_q;
  assign XFER_CNT    = xfer_q;
  assign TIMEOUT_ERR = timeout_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Bench for dma_bus_arbiter: directed bus-tenure scenarios, a flag/countdown model of
// the arbitration rules checked every cycle, plus hand-computed literal checkpoints.
module tb_dma_bus_arbiter;

  localparam int MaxX    = 16;
  localparam int Backoff = 4;
  localparam int Timeout = 10;

  logic       CLK = 1'b0;
  logic       nRST, DMAREQ, BGRANT_, BGACK_IN_, AS_, CYCLEDONE;
  logic       BR_, BGACK_, OWN, TIMEOUT_ERR;
  logic [7:0] XFER_CNT;

  int n_vec  = 0;
  int n_fail = 0;

  dma_bus_arbiter #(
    .MAX_XFERS     (MaxX),
    .BACKOFF_CYCLES(Backoff),
    .GRANT_TIMEOUT (Timeout)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .DMAREQ     (DMAREQ),
    .BGRANT_    (BGRANT_),
    .BGACK_IN_  (BGACK_IN_),
    .AS_        (AS_),
    .CYCLEDONE  (CYCLEDONE),
    .BR_        (BR_),
    .BGACK_     (BGACK_),
    .OWN        (OWN),
    .XFER_CNT   (XFER_CNT),
    .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: what the bus owner should be doing, as flags and countdowns.
  bit m_valid = 0;
  bit m_asking, m_granted, m_own, m_rel, m_budget, m_to;
  int m_waited, m_cnt, m_backoff_left;

  task automatic model_step();
    m_to = 0;
    if (!nRST) begin
      m_valid = 1; m_asking = 0; m_granted = 0; m_own = 0; m_rel = 0;
      m_budget = 0; m_waited = 0; m_cnt = 0; m_backoff_left = 0;
    end else if (m_backoff_left > 0) begin
      m_backoff_left--;
    end else if (m_rel) begin
      m_rel = 0;
      if (m_budget) m_backoff_left = Backoff;
    end else if (m_own) begin
      if (CYCLEDONE) begin
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        if (!DMAREQ || m_cnt == MaxX) begin
          m_own = 0; m_rel = 1; m_budget = (m_cnt == MaxX);
        end
      end
    end else if (m_asking && m_granted) begin
      if (BGRANT_) begin
        m_granted = 0; m_waited = 0;
      end else if (AS_ && BGACK_IN_) begin
        m_asking = 0; m_granted = 0; m_own = 1; m_cnt = 0;
      end
    end else if (m_asking) begin
      m_waited++;
      if (!BGRANT_) m_granted = 1;
      else if (!DMAREQ) m_asking = 0;
      else if (m_waited == Timeout) begin
        m_asking = 0; m_to = 1;
      end
    end else if (DMAREQ) begin
      m_asking = 1; m_waited = 0;
    end
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  initial forever begin
    @(negedge CLK);
    if (m_valid) begin
      check("model BR_", int'(BR_), int'(!m_asking));
      check("model BGACK_", int'(BGACK_), int'(!(m_own || m_rel)));
      check("model OWN", int'(OWN), int'(m_own));
      check("model XFER_CNT", int'(XFER_CNT), m_cnt);
      check("model TIMEOUT_ERR", int'(TIMEOUT_ERR), int'(m_to));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulse();
    CYCLEDONE = 1; tick(1);
    CYCLEDONE = 0; tick(1);
  endtask

  task automatic acquire();
    DMAREQ = 1; tick(1);
    BGRANT_ = 0; tick(1);
    tick(1);
    BGRANT_ = 1;
  endtask

  initial begin
    nRST = 0; DMAREQ = 0; BGRANT_ = 1; BGACK_IN_ = 1; AS_ = 1; CYCLEDONE = 0;
    tick(2);
    nRST = 1;
    check("reset BR_", int'(BR_), 1);
    check("reset BGACK_", int'(BGACK_), 1);
    check("reset OWN", int'(OWN), 0);
    check("reset XFER_CNT", int'(XFER_CNT), 0);
    check("reset TIMEOUT_ERR", int'(TIMEOUT_ERR), 0);

    // Basic tenure: grant after 3 clocks, 4 cycles, DMAREQ drops before the 4th.
    DMAREQ = 1; tick(1);
    check("basic BR_ low clk1", int'(BR_), 0);
    tick(2);
    BGRANT_ = 0; tick(1);
    check("basic BGACK_ before free", int'(BGACK_), 1);
    tick(1);
    check("basic BGACK_ owned", int'(BGACK_), 0);
    check("basic OWN", int'(OWN), 1);
    check("basic BR_ negated", int'(BR_), 1);
    BGRANT_ = 1;
    repeat (3) pulse();
    DMAREQ = 0; tick(1);
    check("basic idle hold OWN", int'(OWN), 1);
    CYCLEDONE = 1; tick(1);
    CYCLEDONE = 0;
    check("basic XFER_CNT", int'(XFER_CNT), 4);
    check("basic release OWN", int'(OWN), 0);
    check("basic release BGACK_", int'(BGACK_), 0);
    tick(1);
    check("basic BGACK_ high", int'(BGACK_), 1);

    // Budget: 16 cycles with DMAREQ held, then backoff.
    acquire();
    repeat (15) pulse();
    check("budget cnt 15", int'(XFER_CNT), 15);
    check("budget still own", int'(OWN), 1);
    CYCLEDONE = 1; tick(1);
    CYCLEDONE = 0;
    check("budget cnt 16", int'(XFER_CNT), 16);
    check("budget release OWN", int'(OWN), 0);
    tick(1);
    check("budget BGACK_ off", int'(BGACK_), 1);
    for (int i = 0; i < Backoff; i++) begin
      tick(1);
      check("backoff BR_ high", int'(BR_), 1);
    end
    tick(1);
    check("backoff BR_ reasserted", int'(BR_), 0);

    // Timeout: already in REQUEST, grant never arrives.
    tick(9);
    check("timeout not yet", int'(TIMEOUT_ERR), 0);
    check("timeout BR_ low", int'(BR_), 0);
    tick(1);
    check("timeout pulse", int'(TIMEOUT_ERR), 1);
    check("timeout BR_ high", int'(BR_), 1);
    DMAREQ = 0; tick(1);
    check("timeout one clock", int'(TIMEOUT_ERR), 0);
    check("timeout idle BR_", int'(BR_), 1);

    // DMAREQ falls between cycles: bus held until the next cycle completes.
    acquire();
    DMAREQ = 0; tick(3);
    check("no early release", int'(OWN), 1);
    CYCLEDONE = 1; tick(1);
    CYCLEDONE = 0;
    check("boundary release", int'(OWN), 0);
    check("boundary cnt", int'(XFER_CNT), 1);
    tick(1);
    CYCLEDONE = 1; tick(1);
    CYCLEDONE = 0;
    check("stray CYCLEDONE ignored", int'(XFER_CNT), 1);

    // Bus busy: AS_ low for 5 clocks after grant.
    AS_ = 0; DMAREQ = 1; tick(1);
    BGRANT_ = 0; tick(1);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("busy BGACK_ high", int'(BGACK_), 1);
      check("busy BR_ low", int'(BR_), 0);
    end
    AS_ = 1; tick(1);
    check("busy BGACK_ asserted", int'(BGACK_), 0);
    check("busy BR_ released", int'(BR_), 1);
    BGRANT_ = 1;

    // Mid-tenure reset at XFER_CNT=7.
    repeat (7) pulse();
    check("midreset cnt 7", int'(XFER_CNT), 7);
    nRST = 0; tick(1);
    check("midreset BR_", int'(BR_), 1);
    check("midreset BGACK_", int'(BGACK_), 1);
    check("midreset OWN", int'(OWN), 0);
    check("midreset XFER_CNT", int'(XFER_CNT), 0);

    // Withdrawn grant while AS_ low: back to REQUEST with a fresh timeout window.
    nRST = 1; AS_ = 0; tick(1);
    check("withdraw BR_ req", int'(BR_), 0);
    BGRANT_ = 0; tick(1);
    BGRANT_ = 1; tick(1);
    check("withdraw BR_ held", int'(BR_), 0);
    check("withdraw no BGACK_", int'(BGACK_), 1);
    tick(9);
    check("withdraw wait cleared", int'(TIMEOUT_ERR), 0);
    check("withdraw BGACK_ never", int'(BGACK_), 1);
    tick(1);
    check("withdraw timeout", int'(TIMEOUT_ERR), 1);
    DMAREQ = 0; AS_ = 1; tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
